multicycle_alu: RTL and testbench

- Responder end of the control unit's ALU_Start/ALU_Done handshake: executes ADD, SUB, MUL and DIV on 16-bit operands.
- ADD and SUB complete in one cycle. MUL (shift-add) and DIV (restoring) iterate over WIDTH cycles.
- Drives the ALU_* signals that the control unit samples in its EXEC state. Latches the result so WB can consume it later.

---
 rtl/multicycle_alu.sv | 171 +++++++++++++++++
 tb/tb_multicycle_alu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: responder side of the ALU_Start/ALU_Done handshake (ADD, SUB, MUL, DIV).
// Latency: ADD/SUB/DIV-by-zero finish 1 cycle after accept; MUL/DIV spend WIDTH cycles in RUN (Done at cycle WIDTH+1).
// Backpressure: none; a request is accepted only from IDLE while armed, and Start must drop for one edge to re-arm.
//
// Ports:
//   Clock, Reset        - rising-edge clock, asynchronous active-high reset
//   ALUOP, ALU_A, ALU_B - operation (00 ADD, 01 SUB, 10 MUL, 11 DIV) and operands, latched on accept
//   ALU_Start           - request, held high by the initiator until it samples ALU_Done
//   ALU_Result          - registered result, written only on entry to DONE
//   ALU_Done, ALU_Busy  - registered one-cycle completion pulse / multicycle-in-progress flag
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       ALUOP,
  input  logic [WIDTH-1:0] ALU_A,
  input  logic [WIDTH-1:0] ALU_B,
  input  logic             ALU_Start,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             ALU_Done,
  output logic             ALU_Busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int         CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  // x: multiplicand (shifts left) for MUL, dividend shifting out / quotient shifting in for DIV
  // y: multiplier (shifts right) for MUL, divisor for DIV
  // acc: partial product for MUL, partial remainder for DIV
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  always_comb begin
    // One shift-add step: only the low WIDTH product bits are ever kept.
    mul_acc = y_q[0] ? (acc_q + x_q) : acc_q;

    // One restoring-division step: bring down the next dividend bit, subtract if it fits.
    rem_sh  = {acc_q, x_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, y_q};
    div_ge  = (rem_sh >= {1'b0, y_q});
    div_rem = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_quo = {x_q[WIDTH-2:0], div_ge};

    state_d  = state_q;
    armed_d  = armed_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ALU_Start && armed_q) begin
          armed_d = 1'b0;
          x_d     = ALU_A;
          y_d     = ALU_B;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          if (ALUOP == OP_ADD) begin
            result_d = ALU_A + ALU_B;
            state_d  = DONE;
            done_d   = 1'b1;
          end else if (ALUOP == OP_SUB) begin
            result_d = ALU_A - ALU_B;
            state_d  = DONE;
            done_d   = 1'b1;
          end else if (ALUOP == OP_MUL) begin
            state_d = MUL_RUN;
            busy_d  = 1'b1;
          end else if (ALU_B == '0) begin
            // Divide by zero short-circuits to all ones without iterating.
            result_d = '1;
            state_d  = DONE;
            done_d   = 1'b1;
          end else begin
            state_d = DIV_RUN;
            busy_d  = 1'b1;
          end
        end
      end

      MUL_RUN: begin
        acc_d = mul_acc;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        if (cnt_q == '0) begin
          result_d = mul_acc;
          state_d  = DONE;
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end
      end

      DIV_RUN: begin
        acc_d = div_rem;
        x_d   = div_quo;
        if (cnt_q == '0) begin
          result_d = div_quo;
          state_d  = DONE;
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        // DONE lasts one cycle; Start is deliberately ignored here.
        state_d = IDLE;
      end
    endcase

    // Any edge with Start low re-arms, so a Start held across Done cannot relaunch.
    if (!ALU_Start) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      armed_q  <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ALU_Result = result_q;
  assign ALU_Done   = done_q;
  assign ALU_Busy   = busy_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu: directed handshake sequences against a latency/arithmetic model.
// The model predicts Done/Busy/Result every cycle from plain +, -, *, / and a cycle countdown.
// Directed tasks additionally pin literal results, latencies and Busy durations.
module tb_multicycle_alu;

  logic        Clock;
  logic        Reset;
  logic [1:0]  ALUOP;
  logic [15:0] ALU_A;
  logic [15:0] ALU_B;
  logic        ALU_Start;
  logic [15:0] ALU_Result;
  logic        ALU_Done;
  logic        ALU_Busy;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;
  int exp_pulses = 0;
  bit cmp_en = 1'b0;

  multicycle_alu #(.WIDTH(16)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ALUOP      (ALUOP),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_Start  (ALU_Start),
    .ALU_Result (ALU_Result),
    .ALU_Done   (ALU_Done),
    .ALU_Busy   (ALU_Busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: an accepted request either completes at once or after
  // 16 more edges; the answer comes from ordinary arithmetic on the operands.
  logic        m_done;
  logic        m_busy;
  logic        m_armed;
  logic [15:0] m_res;
  logic [15:0] m_pend;
  int          m_left;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_done  <= 1'b0;
      m_busy  <= 1'b0;
      m_armed <= 1'b1;
      m_res   <= 16'h0000;
      m_pend  <= 16'h0000;
      m_left  <= 0;
    end else begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_res  <= m_pend;
        end
      end else if (ALU_Start && m_armed) begin
        m_armed <= 1'b0;
        case (ALUOP)
          2'b00: begin m_res <= ALU_A + ALU_B; m_done <= 1'b1; end
          2'b01: begin m_res <= ALU_A - ALU_B; m_done <= 1'b1; end
          2'b10: begin m_pend <= ALU_A * ALU_B; m_left <= 16; m_busy <= 1'b1; end
          default: begin
            if (ALU_B == 16'h0000) begin
              m_res  <= 16'hFFFF;
              m_done <= 1'b1;
            end else begin
              m_pend <= ALU_A / ALU_B;
              m_left <= 16;
              m_busy <= 1'b1;
            end
          end
        endcase
      end
      if (!ALU_Start) m_armed <= 1'b1;
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("cycle done", ALU_Done, m_done);
      chk("cycle busy", ALU_Busy, m_busy);
      chk("cycle result", ALU_Result, m_res);
      if (ALU_Done) dut_pulses++;
    end
  end

  // Issues one request at a negedge, holds Start until Done (bounded), checks
  // literal result/latency/busy, optionally holds Start past Done, then drops it.
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input int exp_lat, input int exp_busy,
                       input int hold, input int gap, input bit scramble, input string nm);
    int lat;
    int bcyc;
    int extra;
    lat   = 0;
    bcyc  = 0;
    extra = 0;
    ALUOP     = op;
    ALU_A     = a;
    ALU_B     = b;
    ALU_Start = 1'b1;
    @(posedge Clock);
    do begin
      @(negedge Clock);
      lat++;
      if (ALU_Busy) bcyc++;
      if (scramble && lat == 1) begin
        ALU_A = 16'h0000;
        ALU_B = 16'h0000;
        ALUOP = 2'b00;
      end
    end while (!ALU_Done && lat < 40);
    chk({nm, " done seen"}, ALU_Done, 1);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " busy cycles"}, bcyc, exp_busy);
    chk({nm, " result"}, ALU_Result, exp_res);
    exp_pulses++;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      if (ALU_Done) extra++;
    end
    if (hold > 0) chk({nm, " extra done pulses"}, extra, 0);
    ALU_Start = 1'b0;
    @(negedge Clock);
    repeat (gap) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset     = 1'b1;
    ALU_Start = 1'b0;
    ALUOP     = 2'b00;
    ALU_A     = 16'h0000;
    ALU_B     = 16'h0000;
    repeat (2) @(negedge Clock);
    chk("reset done", ALU_Done, 0);
    chk("reset busy", ALU_Busy, 0);
    chk("reset result", ALU_Result, 16'h0000);
    Reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge Clock);

    do_op(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 0, 1'b0, "add_ovf");
    do_op(2'b01, 16'd3, 16'd5, 16'hFFFE, 1, 0, 0, 0, 1'b0, "sub_neg");
    do_op(2'b10, 16'd300, 16'd300, 16'h5F90, 17, 16, 0, 0, 1'b1, "mul_300");
    do_op(2'b11, 16'd1000, 16'd7, 16'h008E, 17, 16, 0, 0, 1'b0, "div_1000_7");
    do_op(2'b11, 16'd5, 16'd0, 16'hFFFF, 1, 0, 0, 0, 1'b0, "div_by_zero");

    // Start held across Done must not relaunch; one low edge re-arms.
    do_op(2'b00, 16'd10, 16'd20, 16'h001E, 1, 0, 3, 0, 1'b0, "add_hold");
    do_op(2'b00, 16'd2, 16'd2, 16'h0004, 1, 0, 0, 0, 1'b0, "add_rearm");

    // Asynchronous reset partway through a multiply.
    ALUOP     = 2'b10;
    ALU_A     = 16'd300;
    ALU_B     = 16'd300;
    ALU_Start = 1'b1;
    @(posedge Clock);
    repeat (8) @(negedge Clock);
    chk("mul busy before reset", ALU_Busy, 1);
    #2 Reset = 1'b1;
    ALU_Start = 1'b0;
    #1;
    chk("async reset done", ALU_Done, 0);
    chk("async reset busy", ALU_Busy, 0);
    chk("async reset result", ALU_Result, 16'h0000);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    do_op(2'b00, 16'd1, 16'd1, 16'h0002, 1, 0, 0, 0, 1'b0, "add_after_reset");

    // Control-unit spacing: WB, FETCH, DECODE idle cycles between requests.
    do_op(2'b01, 16'd100, 16'd1, 16'h0063, 1, 0, 0, 3, 1'b0, "cu_sub");
    do_op(2'b10, 16'd255, 16'd257, 16'hFFFF, 17, 16, 0, 3, 1'b0, "cu_mul");
    do_op(2'b11, 16'hFFFF, 16'd16, 16'h0FFF, 17, 16, 0, 3, 1'b0, "cu_div");
    do_op(2'b11, 16'd7, 16'd9, 16'h0000, 17, 16, 0, 3, 1'b0, "cu_div_small");

    repeat (2) @(negedge Clock);
    chk("total done pulses", dut_pulses, exp_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
